// File: rtl/hc_pkg.sv
// Shared types and defaults for the cache-line read streamer.
// Widths here are the default build; modules take them as parameter defaults.
package hc_pkg;

    localparam int CL_DATA_W     = 512;
    localparam int CL_ADDR_W     = 42;
    localparam int LINE_CNT_W    = 16;
    localparam int RD_FIFO_DEPTH = 64;

    typedef logic [CL_ADDR_W-1:0]  t_cl_addr;
    typedef logic [CL_DATA_W-1:0]  t_cl_data;
    typedef logic [LINE_CNT_W-1:0] t_line_count;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_REQ   = 2'd1,
        RS_DRAIN = 2'd2,
        RS_DONE  = 2'd3
    } t_rd_stream_state;

    // Credit counter must hold the full buffer depth, hence one extra bit.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hc_read_streamer_if.sv
// Request, response and output-stream signals of the read streamer.
// master = the streamer itself, slave = memory side plus downstream consumer.
interface hc_read_streamer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 42
) ();

    logic                  rd_req_valid;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic                  rd_req_almfull;
    logic                  rd_rsp_valid;
    logic [DATA_WIDTH-1:0] rd_rsp_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output rd_req_valid,
        output rd_req_addr,
        input  rd_req_almfull,
        input  rd_rsp_valid,
        input  rd_rsp_data,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  rd_req_valid,
        input  rd_req_addr,
        output rd_req_almfull,
        output rd_rsp_valid,
        output rd_rsp_data,
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/hc_stream_fifo.sv
// First-word-fall-through buffer: head entry is visible on deq_data_o while not empty.
// Payload storage is not reset; only pointers and occupancy are.
module hc_stream_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enq_i,
    input  logic [DATA_WIDTH-1:0]  enq_data_i,
    input  logic                   deq_i,
    output logic [DATA_WIDTH-1:0]  deq_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  do_deq;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_deq  = deq_i && !empty_o;

    // Drive zero when empty so the output port has a defined idle value.
    assign deq_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_i)  wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_deq) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({enq_i, do_deq})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq_i) mem_q[wr_ptr_q] <= enq_data_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream credit throttling must keep writes away from a full buffer.
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!reset_n) !(enq_i && full_o));

endmodule

// File: rtl/hc_read_streamer.sv
// Issues num_lines sequential cache-line reads from base_addr and streams the in-order
// responses out; credits bound outstanding reads to the buffer depth, so no response backpressure.
module hc_read_streamer
    import hc_pkg::*;
#(
    parameter int DATA_WIDTH = CL_DATA_W,
    parameter int ADDR_WIDTH = CL_ADDR_W,
    parameter int LEN_WIDTH  = LINE_CNT_W,
    parameter int FIFO_DEPTH = RD_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_lines,
    output logic                  busy,
    output logic                  done,
    hc_read_streamer_if.master    bus
);

    localparam int CW = credit_w(FIFO_DEPTH);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = RS_IDLE;
    localparam logic [1:0] S_REQ   = RS_REQ;
    localparam logic [1:0] S_DRAIN = RS_DRAIN;
    localparam logic [1:0] S_DONE  = RS_DONE;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  num_q, num_d;
    logic [LEN_WIDTH-1:0]  req_cnt_q, req_cnt_d;
    logic [LEN_WIDTH-1:0]  rsp_cnt_q, rsp_cnt_d;
    logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  req_vld_q, req_vld_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  rsp_vld_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic                  issue;
    logic                  xfer;
    logic                  rsp_accept;
    logic                  last_req;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;

    assign busy = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    assign issue      = (state_q == S_REQ) && (credits_q != '0) && !bus.rd_req_almfull;
    assign xfer       = !fifo_empty && bus.out_ready;
    assign last_req   = (req_cnt_q == num_q - LEN_WIDTH'(1));
    // Responses outside an active run, or beyond the requested count, are stale and dropped.
    assign rsp_accept = bus.rd_rsp_valid && busy && (rsp_cnt_q != num_q);

    assign bus.rd_req_valid = req_vld_q;
    assign bus.rd_req_addr  = req_addr_q;
    assign bus.out_valid    = !fifo_empty;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q + LEN_WIDTH'(rsp_accept);
        pop_cnt_d  = pop_cnt_q + LEN_WIDTH'(xfer);
        req_vld_d  = 1'b0;
        req_addr_d = req_addr_q;

        case ({issue, xfer})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_d    = base_addr;
                    num_d     = num_lines;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    pop_cnt_d = '0;
                    credits_d = CREDIT_MAX;
                    state_d   = (num_lines == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (issue) begin
                    req_vld_d  = 1'b1;
                    req_addr_d = base_q + ADDR_WIDTH'(req_cnt_q);
                    req_cnt_d  = req_cnt_q + LEN_WIDTH'(1);
                    if (last_req) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look ahead by this cycle's transfer so done follows the last pop directly.
                if (pop_cnt_d == num_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control / request stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            credits_q  <= CREDIT_MAX;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            rsp_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            credits_q  <= credits_d;
            req_vld_q  <= req_vld_d;
            req_addr_q <= req_addr_d;
            rsp_vld_q  <= rsp_accept;
        end
    end

    // Response capture stage
    always_ff @(posedge clk) begin
        if (rsp_accept) rsp_data_q <= bus.rd_rsp_data;
    end

    hc_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .enq_i      (rsp_vld_q),
        .enq_data_i (rsp_data_q),
        .deq_i      (xfer),
        .deq_data_o (bus.out_data),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    // Buffered lines plus remaining credits can never exceed the buffer size.
    a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
        ({1'b0, fifo_count} + {1'b0, credits_q}) <= (CW+1)'(FIFO_DEPTH));
    a_no_full_enq: assert property (@(posedge clk) disable iff (!reset_n) !(fifo_full && rsp_vld_q));

endmodule

// File: tb/tb_hc_read_streamer.sv
// Scoreboard bench for hc_read_streamer: directed runs, memory responder with fixed latency,
// request and output monitors popping expected values pushed by the stimulus.
module tb_hc_read_streamer;

    localparam int DW = 512;
    localparam int AW = 42;
    localparam int LW = 16;
    localparam int FD = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] num_lines;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    hc_read_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    hc_read_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int req_seen = 0;
    int xfer_seen = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [AW-1:0] pend_q[$];

    logic          alm_at_edge = 1'b0;
    bit            done_chk = 1'b0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] rsp_a;

    // Memory contents: each line is a fixed function of its address.
    function automatic logic [DW-1:0] rsp_for(input logic [AW-1:0] a);
        return {a, ~a, {107{4'h5}} ^ 428'(a)};
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=none expected=event", nm);
    endtask

    always @(posedge clk) alm_at_edge <= bus.rd_req_almfull;

    // Responder: answers each request one cycle after it is seen, plus request checking.
    always @(negedge clk) begin
        if (pend_q.size() > 0) begin
            rsp_a = pend_q.pop_front();
            bus.rd_rsp_valid = 1'b1;
            bus.rd_rsp_data  = rsp_for(rsp_a);
        end else begin
            bus.rd_rsp_valid = 1'b0;
            bus.rd_rsp_data  = '0;
        end
        if (bus.rd_req_valid === 1'b1) begin
            req_seen++;
            check("req_while_almfull", DW'(alm_at_edge), DW'(0));
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req actual=%0h expected=no_request", bus.rd_req_addr);
            end else begin
                check("req_addr", DW'(bus.rd_req_addr), DW'(exp_addr_q.pop_front()));
            end
            pend_q.push_back(bus.rd_req_addr);
        end
    end

    // Output monitor: in-order data, hold stability, done timing after the last transfer.
    always @(negedge clk) begin
        if (done_chk) begin
            done_chk = 1'b0;
            check("done_busy_after_last", DW'({done, busy}), DW'(2'b10));
        end
        if (prev_hold && bus.out_valid === 1'b1)
            check("out_data_stable", bus.out_data, prev_data);
        prev_hold = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        prev_data = bus.out_data;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            xfer_seen++;
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%0h expected=no_output", bus.out_data);
            end else begin
                check("out_data", bus.out_data, exp_data_q.pop_front());
                if (exp_data_q.size() == 0) begin
                    check("done_before_last", DW'(done), DW'(0));
                    done_chk = 1'b1;
                end
            end
        end
    end

    task automatic push_run(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(rsp_for(a));
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input int n);
        base_addr = b;
        num_lines = LW'(n);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit alm, input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (alm && (c % 3 == 2)) bus.rd_req_almfull = ~bus.rd_req_almfull;
            if (done && exp_data_q.size() == 0 && exp_addr_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        bus.rd_req_almfull = 1'b0;
        check(nm, DW'(ok), DW'(1));
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_busy"},      DW'(busy),             DW'(0));
        check({nm, "_done"},      DW'(done),             DW'(0));
        check({nm, "_req_valid"}, DW'(bus.rd_req_valid), DW'(0));
        check({nm, "_req_addr"},  DW'(bus.rd_req_addr),  DW'(0));
        check({nm, "_out_valid"}, DW'(bus.out_valid),    DW'(0));
        check({nm, "_out_data"},  bus.out_data,          DW'(0));
    endtask

    initial begin
        int r0;
        int x0;
        bit ok;
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_lines = '0;
        bus.out_ready = 1'b1;
        bus.rd_req_almfull = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 reset_n = 1'b1;

        // Basic: 8 lines from 0x100
        r0 = req_seen;
        push_run(42'h100, 8);
        pulse_start(42'h100, 8);
        wait_done(300, 1'b0, "basic_complete");
        check("basic_req_count", DW'(req_seen - r0), DW'(8));

        // Backpressure: credits stop issue at the buffer depth
        r0 = req_seen;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        push_run(42'h2000, 200);
        pulse_start(42'h2000, 200);
        repeat (150) @(negedge clk);
        check("bp_req_capped", DW'(req_seen - r0), DW'(64));
        check("bp_busy", DW'(busy), DW'(1));
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_done(2000, 1'b0, "bp_complete");
        check("bp_req_total", DW'(req_seen - r0), DW'(200));

        // Almost-full toggling every 3 cycles
        r0 = req_seen;
        push_run(42'h5000, 20);
        pulse_start(42'h5000, 20);
        wait_done(600, 1'b1, "alm_complete");
        check("alm_req_total", DW'(req_seen - r0), DW'(20));

        // Zero length
        r0 = req_seen;
        pulse_start(42'h999, 0);
        @(negedge clk);
        check("zero_done_busy", DW'({done, busy}), DW'(2'b10));
        repeat (6) @(negedge clk);
        check("zero_req_count", DW'(req_seen - r0), DW'(0));
        check("zero_busy_later", DW'(busy), DW'(0));

        // Address wrap at the top of the address space
        r0 = req_seen;
        exp_addr_q.push_back(42'h3FF_FFFF_FFFE);
        exp_addr_q.push_back(42'h3FF_FFFF_FFFF);
        exp_addr_q.push_back(42'h000_0000_0000);
        exp_addr_q.push_back(42'h000_0000_0001);
        exp_data_q.push_back(rsp_for(42'h3FF_FFFF_FFFE));
        exp_data_q.push_back(rsp_for(42'h3FF_FFFF_FFFF));
        exp_data_q.push_back(rsp_for(42'h000_0000_0000));
        exp_data_q.push_back(rsp_for(42'h000_0000_0001));
        pulse_start(42'h3FF_FFFF_FFFE, 4);
        wait_done(300, 1'b0, "wrap_complete");
        check("wrap_req_count", DW'(req_seen - r0), DW'(4));

        // Reset in the middle of a 32-line run
        x0 = xfer_seen;
        push_run(42'h8000, 32);
        pulse_start(42'h8000, 32);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (xfer_seen - x0 >= 10) begin
                ok = 1'b1;
                break;
            end
        end
        check("midrst_reached_10", DW'(ok), DW'(1));
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        pend_q.delete();
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) pend_q.push_back(42'h8010 + AW'(i));
        repeat (10) begin
            @(negedge clk);
            check("stale_out_valid", DW'(bus.out_valid), DW'(0));
        end
        check("stale_busy", DW'(busy), DW'(0));
        check("stale_done", DW'(done), DW'(0));

        r0 = req_seen;
        push_run(42'h40, 4);
        pulse_start(42'h40, 4);
        wait_done(300, 1'b0, "post_rst_complete");
        check("post_rst_req_count", DW'(req_seen - r0), DW'(4));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        fail_now("global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hc_read_streamer.md
# hc_read_streamer

Read-side streaming engine that feeds a downstream line consumer (e.g. a loopback or compute stage). On `start` it issues `num_lines` sequential cache-line read requests from `base_addr` and presents the in-order responses as a valid/ready stream. Credit-based issue throttling guarantees the internal buffer never overflows, so the response port needs no backpressure.

## Interface

Parameters:
- DATA_WIDTH, 512, cache-line payload bits
- ADDR_WIDTH, 42, cache-line address bits
- LEN_WIDTH, 16, line-count bits
- FIFO_DEPTH, 64, output buffer entries; power of two, ≥ 4

Ports:
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE or DONE
- base_addr  in  ADDR_WIDTH  first line address; captured on accepted start
- num_lines  in  LEN_WIDTH  lines to read; captured on accepted start
- busy  out  1  high in REQ and DRAIN
- done  out  1  high in DONE until next accepted start
- rd_req_valid  out  1  read request strobe, one line per cycle
- rd_req_addr  out  ADDR_WIDTH  request address
- rd_req_almfull  in  1  request channel almost full; no issue while high
- rd_rsp_valid  in  1  read response strobe, in request order
- rd_rsp_data  in  DATA_WIDTH  response payload
- out_valid  out  1  stream data available
- out_data  out  DATA_WIDTH  stream payload
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready

## Operation

- States: IDLE → REQ → DRAIN → DONE → (start) REQ.
- IDLE/DONE + start: capture base_addr, num_lines; clear req_cnt, rsp_cnt, pop_cnt. If num_lines == 0 go to DONE, else REQ.
- REQ: issue when credits > 0 and !rd_req_almfull; rd_req_addr = base_addr + req_cnt (ADDR_WIDTH modulo, wraps silently). After issuing request num_lines−1 go to DRAIN.
- DRAIN: wait until pop_cnt == num_lines, then DONE.
- Credits: reset/start value FIFO_DEPTH; −1 per issued request, +1 per output transfer; both in one cycle → unchanged. Credits never exceed FIFO_DEPTH nor go negative.
- Responses: every rd_rsp_valid in REQ/DRAIN enqueues rd_rsp_data and increments rsp_cnt. Responses in IDLE/DONE, or when rsp_cnt == num_lines, are dropped (stale traffic after reset or overrun).
- start during REQ/DRAIN ignored.
- Reset mid-operation: all counters, credits, FIFO cleared; state IDLE; in-flight responses arriving later are dropped per above.

## Timing

- Reset values: busy 0, done 0, rd_req_valid 0, rd_req_addr 0, out_valid 0, out_data 0.
- rd_req_valid and rd_req_addr registered: first request earliest 1 cycle after start; sustained 1 request/cycle while credits and !almfull.
- rd_rsp_valid → enqueue registered (1 cycle) → first-word-fall-through FIFO: out_valid 2 cycles after rd_rsp_valid when FIFO was empty.
- out_data stable while out_valid & !out_ready.
- done rises the cycle after the final output transfer; busy falls the same cycle.
- Full throughput: out_ready held high, no almfull → one line/cycle steady state.

## Structure

- Shared package hc_pkg: t_cl_addr (ADDR_WIDTH), t_cl_data (DATA_WIDTH), t_line_count (LEN_WIDTH), state enum t_rd_stream_state.
- One sub-module: hc_stream_fifo (DATA_WIDTH × FIFO_DEPTH, FWFT, enq/deq/empty/full/count); full must never assert in use, assertion checks this.

## Test plan

- Basic: base_addr 0x100, num_lines 8, out_ready=1, 1-cycle response latency → addresses 0x100..0x107, 8 transfers in order, done high 1 cycle after 8th transfer.
- Backpressure: num_lines 200, FIFO_DEPTH 64, out_ready=0 → exactly 64 requests, then none; raising out_ready resumes, all 200 delivered in order.
- Almfull: toggle rd_req_almfull every 3 cycles → no rd_req_valid while high; total requests = num_lines.
- Zero length: num_lines 0 → no requests, done 1 the cycle after start, busy never high.
- Wrap: base_addr all-ones−1, num_lines 4 → addresses max−1, max, 0, 1.
- Reset mid-run: assert reset_n low after 10 of 32 lines, release, inject 5 stale responses → outputs reset values, no out_valid, IDLE; subsequent 4-line run completes correctly.
